// File: rtl/eon_pkg.sv
// Shared types for the writeback stage: retire-buffer entry layout and the
// youngest-match forwarding lookup used by the decode-stage bypass.
package eon_pkg;

    localparam int width     = 32;
    localparam int rsWidth   = 5;
    // Upper bound on retire-buffer depth supported by fwd_lookup.
    localparam int MAX_DEPTH = 16;

    typedef struct packed {
        logic               we;
        logic [rsWidth-1:0] rd;
        logic [width-1:0]   data;
    } wb_entry_t;

    typedef struct packed {
        logic             hit;
        logic [width-1:0] data;
    } fwd_t;

    // ents is age-ordered (index 0 = oldest), so later matches overwrite earlier ones.
    function automatic fwd_t fwd_lookup(input wb_entry_t [MAX_DEPTH-1:0] ents,
                                        input logic [MAX_DEPTH-1:0]      vld,
                                        input logic [rsWidth-1:0]        rs);
        fwd_t r;
        r = '0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (vld[k] && ents[k].we && (ents[k].rd != '0) && (ents[k].rd == rs)) begin
                r.hit  = 1'b1;
                r.data = ents[k].data;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage result handshake, register-file write port and decode forwarding lookup.
// slave is the writeback stage; master is the surrounding pipeline.
interface wb_stage_if;
    import eon_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [rsWidth-1:0] in_rd;
    logic               in_we;
    logic [width-1:0]   in_data;

    logic               rf_ready;
    logic               rf_we;
    logic [rsWidth-1:0] rf_rd;
    logic [width-1:0]   rf_data;

    logic [rsWidth-1:0] rs1;
    logic [rsWidth-1:0] rs2;
    logic               fwd1_hit;
    logic               fwd2_hit;
    logic [width-1:0]   fwd1_data;
    logic [width-1:0]   fwd2_data;

    modport slave (
        input  in_valid, in_rd, in_we, in_data, rf_ready, rs1, rs2,
        output in_ready, rf_we, rf_rd, rf_data, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );

    modport master (
        output in_valid, in_rd, in_we, in_data, rf_ready, rs1, rs2,
        input  in_ready, rf_we, rf_rd, rf_data, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order DEPTH-entry FIFO of wb_entry_t; one-cycle write-to-read latency, push ignored when full.
// Entries are exposed age-ordered (index 0 = head) with a valid mask for parallel lookup.
module wb_fifo
    import eon_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  wdata,
    input  logic                       pop,
    output wb_entry_t [DEPTH-1:0]      ents,
    output logic [DEPTH-1:0]           vld,
    output logic [$clog2(DEPTH):0]     occ
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && (occ != FULL);
    assign pop_ok  = pop && (occ != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload needs no reset: validity is carried entirely by occ.
    always_ff @(posedge clk) begin
        if (push_ok) mem[tail] <= wdata;
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ents[k] = mem[head + PW'(k)];
            vld[k]  = ((PW+1)'(k) < occ);
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback retire buffer: results wait at least one cycle, drain one per rf_ready cycle, in order.
// in_ready drops only when full (no same-cycle pop credit); forwarding and rf_* are combinational.
module wb_stage
    import eon_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int cntWidth = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_stage_if.slave              bus,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [cntWidth-1:0]    retire_count
);

    localparam logic [$clog2(DEPTH):0] FULL = ($clog2(DEPTH)+1)'(DEPTH);

    wb_entry_t                  in_ent;
    wb_entry_t [DEPTH-1:0]      ents;
    logic [DEPTH-1:0]           vld;
    logic                       pop;
    wb_entry_t [MAX_DEPTH-1:0]  pad_ents;
    logic [MAX_DEPTH-1:0]       pad_vld;
    fwd_t                       fwd1;
    fwd_t                       fwd2;

    assign in_ent.we   = bus.in_we;
    assign in_ent.rd   = bus.in_rd;
    assign in_ent.data = bus.in_data;

    assign bus.in_ready = (occupancy != FULL);
    assign pop          = (occupancy != '0) && bus.rf_ready;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid && bus.in_ready),
        .wdata (in_ent),
        .pop   (pop),
        .ents  (ents),
        .vld   (vld),
        .occ   (occupancy)
    );

    // Head is shown only while valid so an empty buffer presents zeros, never stale data.
    assign bus.rf_rd   = vld[0] ? ents[0].rd   : '0;
    assign bus.rf_data = vld[0] ? ents[0].data : '0;
    assign bus.rf_we   = pop && ents[0].we && (ents[0].rd != '0);

    always_comb begin
        pad_ents = '0;
        pad_vld  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pad_ents[k] = ents[k];
            pad_vld[k]  = vld[k];
        end
    end

    // The head being popped this cycle still forwards; the RF write lands next cycle.
    assign fwd1 = fwd_lookup(pad_ents, pad_vld, bus.rs1);
    assign fwd2 = fwd_lookup(pad_ents, pad_vld, bus.rs2);

    assign bus.fwd1_hit  = fwd1.hit;
    assign bus.fwd1_data = fwd1.data;
    assign bus.fwd2_hit  = fwd2.hit;
    assign bus.fwd2_data = fwd2.data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count <= '0;
        end else if (pop) begin
            retire_count <= retire_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_stage;
    import eon_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  occupancy;
    logic [31:0] retire_count;
    logic [1:0]  occ4;
    logic [3:0]  cnt4;

    int tests = 0;
    int fails = 0;

    wb_entry_t   q[$];
    logic [31:0] cnt;

    wb_stage_if bus();
    wb_stage_if bus4();

    wb_stage #(.DEPTH(DEPTH), .cntWidth(32)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .occupancy(occupancy), .retire_count(retire_count)
    );

    wb_stage #(.DEPTH(DEPTH), .cntWidth(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .occupancy(occ4), .retire_count(cnt4)
    );

    always #5 clk = ~clk;

    // Reference model: retire buffer as a queue, oldest at index 0.
    function automatic logic exp_ready();
        return q.size() < DEPTH;
    endfunction

    function automatic logic exp_we();
        if (q.size() == 0 || !bus.rf_ready) return 1'b0;
        return q[0].we && (q[0].rd != 0);
    endfunction

    function automatic logic [4:0] exp_rd();
        return (q.size() != 0) ? q[0].rd : 5'd0;
    endfunction

    function automatic logic [31:0] exp_rdata();
        return (q.size() != 0) ? q[0].data : 32'd0;
    endfunction

    function automatic logic exp_hit(input logic [4:0] rs);
        foreach (q[i]) if (q[i].we && q[i].rd != 0 && q[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_fdata(input logic [4:0] rs);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].we && q[i].rd != 0 && q[i].rd == rs) return q[i].data;
        return 32'd0;
    endfunction

    task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_we    = we;
        bus.in_rd    = rd;
        bus.in_data  = d;
    endtask

    // Advance one edge and apply the same edge to the model.
    task automatic tick();
        logic      do_pop, do_push;
        wb_entry_t e;
        do_pop  = (q.size() != 0) && bus.rf_ready;
        do_push = bus.in_valid && (q.size() < DEPTH);
        e.we    = bus.in_we;
        e.rd    = bus.in_rd;
        e.data  = bus.in_data;
        @(posedge clk);
        if (do_pop) begin
            void'(q.pop_front());
            cnt = cnt + 1;
        end
        if (do_push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.rs1 = 5'd3;
        bus.rs2 = 5'd9;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tests++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we got %b want 0", bus.rf_we); end
        tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        tests++; if (retire_count !== 32'd0) begin fails++; $display("FAIL reset_count got %0d want 0", retire_count); end
        tests++; if (bus.fwd1_hit !== 1'b0 || bus.fwd2_hit !== 1'b0) begin fails++; $display("FAIL reset_hits got %b%b want 00", bus.fwd1_hit, bus.fwd2_hit); end
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        cnt = 0;
    endtask

    task automatic test_wrap();
        bus4.rf_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            bus4.in_valid = (k < 16);
            bus4.in_we    = 1'b1;
            bus4.in_rd    = 5'd1;
            bus4.in_data  = 32'(k);
            @(posedge clk);
            @(negedge clk);
            #1;
            tests++; if (cnt4 !== 4'(k % 16)) begin fails++; $display("FAIL wrap_count edge %0d got %0d want %0d", k, cnt4, k % 16); end
            tests++; if (occ4 !== ((k < 16) ? 2'd1 : 2'd0)) begin fails++; $display("FAIL wrap_occ edge %0d got %0d", k, occ4); end
        end
        bus4.in_valid = 1'b0;
        bus4.rf_ready = 1'b0;
    endtask

    task automatic test_single();
        bus.rf_ready = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        tests++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL single_no_bypass rf_we got %b want 0", bus.rf_we); end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        tests++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_data !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_write got we=%b rd=%0d data=%h want 1/5/deadbeef", bus.rf_we, bus.rf_rd, bus.rf_data);
        end
        tick();
        #1;
        tests++; if (occupancy !== 2'd0 || retire_count !== 32'd1) begin
            fails++; $display("FAIL single_after occ=%0d count=%0d want 0/1", occupancy, retire_count);
        end
    endtask

    task automatic test_fwd_hold();
        bus.rf_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd3, 32'h11); tick();
        drive(1'b1, 1'b1, 5'd3, 32'h22); tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.rs1 = 5'd3;
        #1;
        tests++; if (bus.in_ready !== 1'b0 || occupancy !== 2'd2) begin fails++; $display("FAIL hold_full in_ready=%b occ=%0d want 0/2", bus.in_ready, occupancy); end
        tests++; if (bus.fwd1_hit !== 1'b1 || bus.fwd1_data !== 32'h22) begin fails++; $display("FAIL hold_fwd hit=%b data=%h want 1/22", bus.fwd1_hit, bus.fwd1_data); end
        tests++; if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd3 || bus.rf_data !== 32'h11) begin fails++; $display("FAIL hold_head we=%b rd=%0d data=%h want 0/3/11", bus.rf_we, bus.rf_rd, bus.rf_data); end
        bus.rf_ready = 1'b1;
        #1;
        tests++; if (bus.rf_we !== 1'b1 || bus.rf_data !== 32'h11) begin fails++; $display("FAIL drain_first we=%b data=%h want 1/11", bus.rf_we, bus.rf_data); end
        tick();
        #1;
        tests++; if (bus.rf_we !== 1'b1 || bus.rf_data !== 32'h22) begin fails++; $display("FAIL drain_second we=%b data=%h want 1/22", bus.rf_we, bus.rf_data); end
        tick();
        #1;
        tests++; if (occupancy !== 2'd0 || retire_count !== cnt) begin fails++; $display("FAIL drain_done occ=%0d count=%0d want 0/%0d", occupancy, retire_count, cnt); end
    endtask

    task automatic test_no_write();
        logic [31:0] start;
        start = cnt;
        bus.rf_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd0, 32'hFF); tick();
        drive(1'b1, 1'b0, 5'd7, 32'h1);  tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd7;
        bus.rf_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL nowrite_we pop %0d got %b want 0", i, bus.rf_we); end
            tests++; if (bus.fwd1_hit !== 1'b0 || bus.fwd2_hit !== 1'b0) begin fails++; $display("FAIL nowrite_hit pop %0d got %b%b want 00", i, bus.fwd1_hit, bus.fwd2_hit); end
            tick();
        end
        #1;
        tests++; if (retire_count !== start + 2) begin fails++; $display("FAIL nowrite_count got %0d want %0d", retire_count, start + 2); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v, next_out;
        logic        acc;
        bus.rf_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd4, 32'd100); tick();
        drive(1'b1, 1'b1, 5'd4, 32'd101); tick();
        v = 102;
        next_out = 100;
        bus.rf_ready = 1'b1;
        for (int c = 0; c < 80 && (v < 122 || q.size() != 0); c++) begin
            drive(v < 122, 1'b1, 5'd4, v);
            #1;
            tests++; if (bus.in_ready !== exp_ready() || occupancy !== 2'(q.size())) begin
                fails++; $display("FAIL b2b_flow cyc %0d in_ready=%b occ=%0d want %b/%0d", c, bus.in_ready, occupancy, exp_ready(), q.size());
            end
            if (q.size() != 0) begin
                tests++; if (bus.rf_we !== 1'b1 || bus.rf_data !== next_out) begin
                    fails++; $display("FAIL b2b_order cyc %0d we=%b data=%0d want 1/%0d", c, bus.rf_we, bus.rf_data, next_out);
                end
                next_out = next_out + 1;
            end
            acc = (v < 122) && exp_ready();
            tick();
            if (acc) v = v + 1;
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tests++; if (next_out !== 32'd122) begin fails++; $display("FAIL b2b_total retired up to %0d want 122", next_out); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), $urandom);
            bus.rf_ready = $urandom_range(0, 2) != 0;
            bus.rs1 = 5'($urandom_range(0, 3));
            bus.rs2 = 5'($urandom_range(0, 3));
            #1;
            tests++; if (bus.in_ready !== exp_ready() || occupancy !== 2'(q.size()) || retire_count !== cnt) begin
                fails++; $display("FAIL rnd_state cyc %0d in_ready=%b occ=%0d cnt=%0d want %b/%0d/%0d", c, bus.in_ready, occupancy, retire_count, exp_ready(), q.size(), cnt);
            end
            tests++; if (bus.rf_we !== exp_we() || bus.rf_rd !== exp_rd() || bus.rf_data !== exp_rdata()) begin
                fails++; $display("FAIL rnd_rf cyc %0d we=%b rd=%0d data=%h want %b/%0d/%h", c, bus.rf_we, bus.rf_rd, bus.rf_data, exp_we(), exp_rd(), exp_rdata());
            end
            tests++; if (bus.fwd1_hit !== exp_hit(bus.rs1) || bus.fwd1_data !== exp_fdata(bus.rs1)) begin
                fails++; $display("FAIL rnd_fwd1 cyc %0d hit=%b data=%h want %b/%h", c, bus.fwd1_hit, bus.fwd1_data, exp_hit(bus.rs1), exp_fdata(bus.rs1));
            end
            tests++; if (bus.fwd2_hit !== exp_hit(bus.rs2) || bus.fwd2_data !== exp_fdata(bus.rs2)) begin
                fails++; $display("FAIL rnd_fwd2 cyc %0d hit=%b data=%h want %b/%h", c, bus.fwd2_hit, bus.fwd2_data, exp_hit(bus.rs2), exp_fdata(bus.rs2));
            end
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_async_reset();
        bus.rf_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd6, 32'hA5); tick();
        drive(1'b1, 1'b1, 5'd6, 32'h5A); tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        // Fill may have been partly blocked by leftover entries; ensure exactly full.
        while (q.size() < DEPTH) begin drive(1'b1, 1'b1, 5'd6, 32'h5A); tick(); end
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.rs1 = 5'd6;
        bus.rf_ready = 1'b1;
        #1;
        tests++; if (bus.rf_we !== 1'b1 || bus.fwd1_hit !== 1'b1 || occupancy !== 2'd2) begin
            fails++; $display("FAIL arst_pre we=%b hit=%b occ=%0d want 1/1/2", bus.rf_we, bus.fwd1_hit, occupancy);
        end
        #1 rst = 1'b1;
        #1;
        q.delete();
        cnt = 0;
        tests++; if (bus.rf_we !== 1'b0 || bus.fwd1_hit !== 1'b0 || occupancy !== 2'd0) begin
            fails++; $display("FAIL arst_now we=%b hit=%b occ=%0d want 0/0/0", bus.rf_we, bus.fwd1_hit, occupancy);
        end
        tests++; if (retire_count !== 32'd0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL arst_ctl count=%0d in_ready=%b want 0/1", retire_count, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (retire_count !== 32'd0 || occupancy !== 2'd0) begin
            fails++; $display("FAIL arst_release count=%0d occ=%0d want 0/0", retire_count, occupancy);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.rf_ready  = 1'b0;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;
        bus4.in_valid = 1'b0;
        bus4.in_we    = 1'b0;
        bus4.in_rd    = 5'd0;
        bus4.in_data  = 32'd0;
        bus4.rf_ready = 1'b0;
        bus4.rs1      = 5'd0;
        bus4.rs2      = 5'd0;
        cnt = 0;

        test_reset();
        test_wrap();
        test_single();
        test_fwd_hold();
        test_no_write();
        test_back_to_back();
        test_random();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
